// File: rtl/painterengine_gpu_writer_scheduler.sv
// rtl/painterengine_gpu_writer_scheduler.sv - round-robin job scheduler for a 4-channel GPU DMA writer
// Arbitrates channel requests, restarts the writer per job, and reports per-channel done/error pulses.
module painterengine_gpu_writer_scheduler #(
    parameter int PARAM_RESTART_CYCLES = 2,
    parameter int PARAM_TIMEOUT_WIDTH  = 20
) (
    input  logic         i_wire_clock,
    input  logic         i_wire_resetn,
    input  logic [3:0]   i_wire_request,
    input  logic [127:0] i_wire_address,
    input  logic [127:0] i_wire_length,
    output logic [3:0]   o_wire_grant,
    output logic [3:0]   o_wire_channel_done,
    output logic [3:0]   o_wire_channel_error,
    output logic [2:0]   o_wire_error_type,
    output logic         o_wire_busy,
    output logic         o_wire_writer_resetn,
    output logic [3:0]   o_wire_writer_router,
    output logic [127:0] o_wire_writer_address,
    output logic [127:0] o_wire_writer_length,
    input  logic         i_wire_writer_done,
    input  logic         i_wire_writer_error,
    input  logic [2:0]   i_wire_writer_error_type
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LAUNCH   = 2'd1,
        S_RUN      = 2'd2,
        S_COMPLETE = 2'd3
    } state_t;

    localparam logic [3:0] L_RESTART_LAST = 4'(PARAM_RESTART_CYCLES - 1);
    localparam logic [PARAM_TIMEOUT_WIDTH-1:0] L_TIMEOUT_ONE = PARAM_TIMEOUT_WIDTH'(1);
    localparam logic [PARAM_TIMEOUT_WIDTH-1:0] L_TIMEOUT_MAX = '1;

    state_t r_state;
    state_t w_next_state;

    logic [3:0]                     r_grant;
    logic [1:0]                     r_idx;
    logic [1:0]                     r_rr_ptr;
    logic [31:0]                    r_addr;
    logic [31:0]                    r_len;
    logic [3:0]                     r_restart_cnt;
    logic [PARAM_TIMEOUT_WIDTH-1:0] r_timeout_cnt;
    logic [3:0]                     r_done;
    logic [3:0]                     r_error;
    logic [2:0]                     r_error_type;
    logic                           r_busy;
    logic                           r_writer_resetn;

    logic                           w_found;
    logic [1:0]                     w_winner;
    logic [1:0]                     w_cand;
    logic [31:0]                    w_win_len;
    logic [31:0]                    w_win_addr;
    logic [PARAM_TIMEOUT_WIDTH-1:0] w_timeout_inc;
    logic                           w_timeout_hit;
    logic                           w_restart_last;

    // Search starts one past the last served channel, so every requester waits at most three jobs.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_rr_ptr;
        w_cand   = r_rr_ptr;
        for (int i = 1; i <= 4; i++) begin
            w_cand = r_rr_ptr + 2'(i);
            if (!w_found && i_wire_request[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    assign w_win_len      = i_wire_length[{w_winner, 5'd0} +: 32];
    assign w_win_addr     = i_wire_address[{w_winner, 5'd0} +: 32];
    assign w_timeout_inc  = r_timeout_cnt + L_TIMEOUT_ONE;
    assign w_timeout_hit  = (w_timeout_inc == L_TIMEOUT_MAX);
    assign w_restart_last = (r_restart_cnt == L_RESTART_LAST);

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next_state = (w_win_len == 32'd0) ? S_COMPLETE : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (w_restart_last) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (i_wire_writer_error || i_wire_writer_done || w_timeout_hit) begin
                    w_next_state = S_COMPLETE;
                end
            end
            S_COMPLETE: w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            r_grant         <= '0;
            r_idx           <= '0;
            r_rr_ptr        <= 2'd3;
            r_addr          <= '0;
            r_len           <= '0;
            r_restart_cnt   <= '0;
            r_timeout_cnt   <= '0;
            r_done          <= '0;
            r_error         <= '0;
            r_error_type    <= '0;
            r_busy          <= 1'b0;
            r_writer_resetn <= 1'b0;
        end else begin
            r_done  <= '0;
            r_error <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant       <= 4'b0001 << w_winner;
                        r_idx         <= w_winner;
                        r_addr        <= w_win_addr;
                        r_len         <= w_win_len;
                        r_busy        <= 1'b1;
                        r_restart_cnt <= '0;
                        r_timeout_cnt <= '0;
                        // An empty job is refused without ever releasing the writer.
                        if (w_win_len == 32'd0) begin
                            r_error      <= 4'b0001 << w_winner;
                            r_error_type <= 3'd6;
                        end
                    end
                end
                S_LAUNCH: begin
                    if (w_restart_last) begin
                        r_writer_resetn <= 1'b1;
                    end else begin
                        r_restart_cnt <= r_restart_cnt + 4'd1;
                    end
                end
                S_RUN: begin
                    r_timeout_cnt <= w_timeout_inc;
                    if (i_wire_writer_error) begin
                        r_error         <= r_grant;
                        r_error_type    <= i_wire_writer_error_type;
                        r_writer_resetn <= 1'b0;
                    end else if (i_wire_writer_done) begin
                        r_done          <= r_grant;
                        r_writer_resetn <= 1'b0;
                    end else if (w_timeout_hit) begin
                        r_error         <= r_grant;
                        r_error_type    <= 3'd7;
                        r_writer_resetn <= 1'b0;
                    end
                end
                S_COMPLETE: begin
                    r_grant         <= '0;
                    r_busy          <= 1'b0;
                    r_rr_ptr        <= r_idx;
                    r_writer_resetn <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_wire_writer_address = '0;
        o_wire_writer_length  = '0;
        for (int k = 0; k < 4; k++) begin
            if (r_grant[k]) begin
                o_wire_writer_address[32*k +: 32] = r_addr;
                o_wire_writer_length[32*k +: 32]  = r_len;
            end
        end
    end

    assign o_wire_grant         = r_grant;
    assign o_wire_writer_router = r_grant;
    assign o_wire_channel_done  = r_done;
    assign o_wire_channel_error = r_error;
    assign o_wire_error_type    = r_error_type;
    assign o_wire_busy          = r_busy;
    assign o_wire_writer_resetn = r_writer_resetn;

endmodule

// File: tb/tb_painterengine_gpu_writer_scheduler.sv
// tb/tb_painterengine_gpu_writer_scheduler.sv - self-checking bench for the GPU writer scheduler
// Directed scenarios plus randomized jobs checked against a job-level arbitration/outcome model.
module tb_painterengine_gpu_writer_scheduler;

    localparam int RESTART = 2;
    localparam int TW      = 4;
    localparam int TMAX    = (1 << TW) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req = '0;
    logic [127:0] addr_v = '0;
    logic [127:0] len_v = '0;
    logic [3:0]   grant, done, err, router;
    logic [2:0]   etype;
    logic         busy, wresetn;
    logic [127:0] waddr, wlen;
    logic         w_done = 1'b0;
    logic         w_err = 1'b0;
    logic [2:0]   w_et = '0;

    int          checks = 0;
    int          errors = 0;
    int          m_rr = 3;
    logic [2:0]  m_et = '0;
    int          wr_mode = 0;
    int          wr_delay = 1;
    logic [2:0]  wr_etype = '0;
    int          run_cnt = 0;

    logic [3:0]   ob_g, ob_router, ob_d, ob_e, ob_post_grant;
    logic         ob_busy, ob_post_busy;
    logic [2:0]   ob_et;
    logic [127:0] ob_a, ob_l;
    int           ob_low, ob_run;
    bit           ob_to;

    always #5 clk = ~clk;

    painterengine_gpu_writer_scheduler #(
        .PARAM_RESTART_CYCLES(RESTART),
        .PARAM_TIMEOUT_WIDTH (TW)
    ) dut (
        .i_wire_clock            (clk),
        .i_wire_resetn           (rst_n),
        .i_wire_request          (req),
        .i_wire_address          (addr_v),
        .i_wire_length           (len_v),
        .o_wire_grant            (grant),
        .o_wire_channel_done     (done),
        .o_wire_channel_error    (err),
        .o_wire_error_type       (etype),
        .o_wire_busy             (busy),
        .o_wire_writer_resetn    (wresetn),
        .o_wire_writer_router    (router),
        .o_wire_writer_address   (waddr),
        .o_wire_writer_length    (wlen),
        .i_wire_writer_done      (w_done),
        .i_wire_writer_error     (w_err),
        .i_wire_writer_error_type(w_et)
    );

    // Writer model: mode 0 done, 1 error, 2 error+done together, 3 silent; fires on RUN cycle wr_delay.
    always @(negedge clk) begin
        if (!wresetn) begin
            run_cnt = 0;
            w_done  = 1'b0;
            w_err   = 1'b0;
            w_et    = '0;
        end else begin
            run_cnt = run_cnt + 1;
            w_done  = (run_cnt == wr_delay) && (wr_mode == 0 || wr_mode == 2);
            w_err   = (run_cnt == wr_delay) && (wr_mode == 1 || wr_mode == 2);
            w_et    = wr_etype;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ($countones(done | err) > 1 || ((done | err) & ~grant) != 4'b0) begin
                errors++;
                $display("FAIL pulse_rule: done=%b error=%b grant=%b", done, err, grant);
            end
            checks++;
            if (wresetn && grant == 4'b0) begin
                errors++;
                $display("FAIL writer_released_idle: writer_resetn=%b grant=%b", wresetn, grant);
            end
        end
    end

    task automatic observe_job(input bit clear_req);
        int t;
        t = 0;
        ob_to = 0; ob_low = 0; ob_run = 0;
        ob_g = '0; ob_router = '0; ob_d = '0; ob_e = '0; ob_et = '0; ob_busy = 1'b0;
        ob_a = '0; ob_l = '0; ob_post_busy = 1'b1; ob_post_grant = 4'hf;
        while (grant == 4'b0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (grant == 4'b0) begin
            ob_to = 1;
            return;
        end
        ob_g      = grant;
        ob_router = router;
        ob_busy   = busy;
        if (clear_req) begin
            req    = '0;
            addr_v = {$urandom, $urandom, $urandom, $urandom};
            len_v  = {$urandom, $urandom, $urandom, $urandom};
        end
        while ((done | err) == 4'b0 && t < 200) begin
            if (wresetn) ob_run++;
            else ob_low++;
            @(negedge clk);
            t++;
        end
        if ((done | err) == 4'b0) begin
            ob_to = 1;
            return;
        end
        ob_d  = done;
        ob_e  = err;
        ob_et = etype;
        ob_a  = waddr;
        ob_l  = wlen;
        @(negedge clk);
        ob_post_busy  = busy;
        ob_post_grant = grant;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        req    = 4'b1111;
        addr_v = {$urandom, $urandom, $urandom, $urandom};
        len_v  = {4{32'd5}};
        repeat (3) @(negedge clk);
        checks++;
        if ({grant, done, err, etype, busy, wresetn, router, waddr, wlen} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: grant=%b done=%b error=%b type=%0d busy=%b wresetn=%b router=%b", grant, done, err, etype, busy, wresetn, router);
        end
        req   = '0;
        rst_n = 1'b1;
        m_rr  = 3;
        m_et  = '0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_seq [5];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_rr = 3; m_et = '0;
        addr_v = {$urandom, $urandom, $urandom, $urandom};
        len_v  = {4{32'd8}};
        wr_mode = 0; wr_delay = 3;
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            observe_job(0);
            checks++;
            if (ob_to) begin errors++; $display("FAIL rr_timeout: job %0d never completed", j); end
            checks++;
            if (ob_g !== exp_seq[j]) begin errors++; $display("FAIL rr_grant: job %0d got %b want %b", j, ob_g, exp_seq[j]); end
            checks++;
            if (ob_low != RESTART) begin errors++; $display("FAIL rr_launch_low: job %0d got %0d want %0d", j, ob_low, RESTART); end
            checks++;
            if (ob_d !== exp_seq[j]) begin errors++; $display("FAIL rr_done: job %0d got %b want %b", j, ob_d, exp_seq[j]); end
        end
        req  = '0;
        m_rr = 0;
    endtask

    task automatic test_single();
        addr_v = '0; len_v = '0;
        addr_v[31:0] = 32'h1000;
        len_v[31:0]  = 32'd16;
        wr_mode = 0; wr_delay = 10;
        req = 4'b0001;
        observe_job(1);
        checks++;
        if (ob_to) begin errors++; $display("FAIL single_timeout: job never completed"); end
        checks++;
        if ({ob_g, ob_router, ob_busy} !== {4'b0001, 4'b0001, 1'b1}) begin errors++; $display("FAIL single_grant: grant=%b router=%b busy=%b want 0001 0001 1", ob_g, ob_router, ob_busy); end
        checks++;
        if (ob_low != RESTART || ob_run != 10) begin errors++; $display("FAIL single_timing: low=%0d run=%0d want %0d 10", ob_low, ob_run, RESTART); end
        checks++;
        if ({ob_d, ob_e} !== {4'b0001, 4'b0000}) begin errors++; $display("FAIL single_pulse: done=%b error=%b want 0001 0000", ob_d, ob_e); end
        checks++;
        if (ob_a !== 128'h1000 || ob_l !== 128'd16) begin errors++; $display("FAIL single_lanes: addr=%h len=%h want 1000 10", ob_a, ob_l); end
        checks++;
        if (ob_post_busy !== 1'b0 || ob_post_grant !== 4'b0) begin errors++; $display("FAIL single_release: busy=%b grant=%b want 0 0000", ob_post_busy, ob_post_grant); end
        m_rr = 0;
    endtask

    task automatic test_zero_length();
        len_v = {4{32'd9}};
        len_v[63:32] = 32'd0;
        req = 4'b0010;
        wr_mode = 0; wr_delay = 2;
        observe_job(1);
        checks++;
        if (ob_to) begin errors++; $display("FAIL zero_timeout: job never completed"); end
        checks++;
        if ({ob_g, ob_d, ob_e} !== {4'b0010, 4'b0000, 4'b0010}) begin errors++; $display("FAIL zero_pulse: grant=%b done=%b error=%b want 0010 0000 0010", ob_g, ob_d, ob_e); end
        checks++;
        if (ob_et !== 3'd6) begin errors++; $display("FAIL zero_type: got %0d want 6", ob_et); end
        checks++;
        if (ob_run != 0 || ob_low != 0) begin errors++; $display("FAIL zero_writer: run=%0d low=%0d want 0 0", ob_run, ob_low); end
        m_rr = 1; m_et = 3'd6;
    endtask

    task automatic test_error_and_done();
        len_v = {4{32'd5}};
        req = 4'b0100;
        wr_mode = 2; wr_delay = 4; wr_etype = 3'd2;
        observe_job(1);
        checks++;
        if (ob_to) begin errors++; $display("FAIL errdone_timeout: job never completed"); end
        checks++;
        if ({ob_d, ob_e} !== {4'b0000, 4'b0100}) begin errors++; $display("FAIL errdone_pulse: done=%b error=%b want 0000 0100", ob_d, ob_e); end
        checks++;
        if (ob_et !== 3'd2 || ob_run != 4) begin errors++; $display("FAIL errdone_type: type=%0d run=%0d want 2 4", ob_et, ob_run); end
        m_rr = 2; m_et = 3'd2;
    endtask

    task automatic test_timeout();
        req = 4'b1000;
        wr_mode = 3; wr_delay = 1;
        observe_job(1);
        checks++;
        if (ob_to) begin errors++; $display("FAIL timeout_timeout: job never completed"); end
        checks++;
        if ({ob_d, ob_e} !== {4'b0000, 4'b1000}) begin errors++; $display("FAIL timeout_pulse: done=%b error=%b want 0000 1000", ob_d, ob_e); end
        checks++;
        if (ob_run != TMAX || ob_et !== 3'd7) begin errors++; $display("FAIL timeout_cycles: run=%0d type=%0d want %0d 7", ob_run, ob_et, TMAX); end
        m_rr = 3; m_et = 3'd7;
    endtask

    task automatic test_reset_mid_run();
        int t;
        len_v = {4{32'd20}};
        wr_mode = 3;
        req = 4'b0100;
        t = 0;
        while (!wresetn && t < 50) begin @(negedge clk); t++; end
        checks++;
        if (!wresetn) begin errors++; $display("FAIL midrun_reach: writer_resetn=%b want 1", wresetn); end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({grant, done, err, etype, busy, wresetn, router, waddr, wlen} !== '0) begin errors++; $display("FAIL midrun_async_clear: grant=%b busy=%b wresetn=%b type=%0d", grant, busy, wresetn, etype); end
        @(negedge clk);
        checks++;
        if ((done | err | grant) !== 4'b0) begin errors++; $display("FAIL midrun_no_pulse: done=%b error=%b grant=%b want 0", done, err, grant); end
        rst_n = 1'b1;
        m_rr = 3; m_et = '0;
        wr_mode = 0; wr_delay = 2;
        observe_job(0);
        req = '0;
        checks++;
        if (ob_to || ob_g !== 4'b0100 || ob_d !== 4'b0100) begin errors++; $display("FAIL midrun_regrant: timeout=%0d grant=%b done=%b want 0100 0100", ob_to, ob_g, ob_d); end
        checks++;
        if (ob_et !== m_et) begin errors++; $display("FAIL midrun_type_cleared: got %0d want %0d", ob_et, m_et); end
        m_rr = 2;
        @(negedge clk);
        wr_mode = 3;
        req = 4'b1011;
        t = 0;
        while (!wresetn && t < 50) begin @(negedge clk); t++; end
        checks++;
        if (grant !== 4'b1000) begin errors++; $display("FAIL midrun2_grant: got %b want 1000", grant); end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_rr = 3;
        wr_mode = 0; wr_delay = 1;
        observe_job(1);
        checks++;
        if (ob_to || ob_g !== 4'b0001 || ob_d !== 4'b0001) begin errors++; $display("FAIL midrun2_from_ch0: timeout=%0d grant=%b done=%b want 0001 0001", ob_to, ob_g, ob_d); end
        m_rr = 0;
    endtask

    task automatic test_random(input int n_jobs);
        logic [31:0]  addr_a [4];
        logic [31:0]  len_a [4];
        logic [3:0]   r;
        logic [3:0]   exp_g, exp_d, exp_e;
        logic [127:0] exp_a, exp_l;
        int           w, exp_low, exp_run;
        for (int j = 0; j < n_jobs; j++) begin
            r = 4'($urandom_range(1, 15));
            for (int k = 0; k < 4; k++) begin
                addr_a[k] = $urandom;
                len_a[k]  = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
                addr_v[32*k +: 32] = addr_a[k];
                len_v[32*k +: 32]  = len_a[k];
            end
            wr_mode  = $urandom_range(0, 3);
            wr_delay = $urandom_range(1, 12);
            wr_etype = 3'($urandom_range(0, 7));
            req = r;
            w = -1;
            for (int s = 1; s <= 4; s++) begin
                if (w < 0 && r[(m_rr + s) % 4]) w = (m_rr + s) % 4;
            end
            exp_g = 4'b0001 << w;
            exp_a = '0; exp_l = '0;
            exp_a[32*w +: 32] = addr_a[w];
            exp_l[32*w +: 32] = len_a[w];
            exp_d = '0; exp_e = '0;
            if (len_a[w] == 32'd0) begin
                exp_low = 0; exp_run = 0; exp_e = exp_g; m_et = 3'd6;
            end else begin
                exp_low = RESTART;
                exp_run = (wr_mode == 3) ? TMAX : wr_delay;
                if (wr_mode == 0) exp_d = exp_g;
                else exp_e = exp_g;
                if (wr_mode == 1 || wr_mode == 2) m_et = wr_etype;
                if (wr_mode == 3) m_et = 3'd7;
            end
            observe_job(j[0]);
            checks++;
            if (ob_to) begin errors++; $display("FAIL rand_timeout: job %0d never completed", j); end
            checks++;
            if (ob_g !== exp_g || ob_router !== exp_g || ob_busy !== 1'b1) begin errors++; $display("FAIL rand_grant: job %0d req=%b grant=%b router=%b busy=%b want %b", j, r, ob_g, ob_router, ob_busy, exp_g); end
            checks++;
            if (ob_low != exp_low || ob_run != exp_run) begin errors++; $display("FAIL rand_timing: job %0d low=%0d run=%0d want %0d %0d", j, ob_low, ob_run, exp_low, exp_run); end
            checks++;
            if (ob_d !== exp_d || ob_e !== exp_e) begin errors++; $display("FAIL rand_pulse: job %0d done=%b error=%b want %b %b", j, ob_d, ob_e, exp_d, exp_e); end
            checks++;
            if (ob_et !== m_et) begin errors++; $display("FAIL rand_type: job %0d got %0d want %0d", j, ob_et, m_et); end
            checks++;
            if (ob_a !== exp_a || ob_l !== exp_l) begin errors++; $display("FAIL rand_lanes: job %0d addr=%h len=%h want %h %h", j, ob_a, ob_l, exp_a, exp_l); end
            checks++;
            if (ob_post_busy !== 1'b0 || ob_post_grant !== 4'b0) begin errors++; $display("FAIL rand_release: job %0d busy=%b grant=%b", j, ob_post_busy, ob_post_grant); end
            m_rr = w;
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_zero_length();
        test_error_and_done();
        test_timeout();
        test_reset_mid_run();
        test_random(40);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/painterengine_gpu_writer_scheduler.md
PAINTERENGINE_GPU_WRITER_SCHEDULER -- requirements
Module: painterengine_gpu_writer_scheduler

Interface
REQ-001 The block SHALL have parameter PARAM_RESTART_CYCLES, default 2, giving writer reset-low cycles before each job launch (valid range 1..15).
REQ-002 The block SHALL have parameter PARAM_TIMEOUT_WIDTH, default 20, giving the run-timeout counter width; timeout fires at count 2^W-1.
REQ-003 The block SHALL have port i_wire_clock, in, 1, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port i_wire_resetn, in, 1, reset, asynchronous, active-low.
REQ-005 The block SHALL have port i_wire_request, in, 4, per-channel job request level.
REQ-006 The block SHALL have port i_wire_address, in, 128, packed per-channel byte address, channel k at [32k+:32].
REQ-007 The block SHALL have port i_wire_length, in, 128, packed per-channel length in 32-bit words.
REQ-008 The block SHALL have port o_wire_grant, out, 4, one-hot channel being served, 0 when idle.
REQ-009 The block SHALL have port o_wire_channel_done, out, 4, one-cycle success pulse for channel k.
REQ-010 The block SHALL have port o_wire_channel_error, out, 4, one-cycle failure pulse for channel k.
REQ-011 The block SHALL have port o_wire_error_type, out, 3, type of the most recent failure, held until the next failure.
REQ-012 The block SHALL have port o_wire_busy, out, 1, high from grant through completion.
REQ-013 The block SHALL have port o_wire_writer_resetn, out, 1, drives the DMA writer's reset.
REQ-014 The block SHALL have port o_wire_writer_router, out, 4, drives the writer's one-hot router select.
REQ-015 The block SHALL have ports o_wire_writer_address and o_wire_writer_length, out, 128 each, latched job values in the granted lane with all other lanes zero.
REQ-016 The block SHALL have ports i_wire_writer_done, in, 1; i_wire_writer_error, in, 1; and i_wire_writer_error_type, in, 3, carrying writer status.

Function
REQ-017 States SHALL be IDLE, LAUNCH, RUN and COMPLETE.
REQ-018 IDLE with any request bit set: winner is the first set bit searching upward, wrapping, from rr_ptr+1 mod 4.
  - On the same edge: latch winner address/length, set grant/router one-hot, set busy, clear restart counter, go to LAUNCH.
  - Grant is visible the cycle after the request is first sampled.
REQ-019 If the winner's latched length is 0, the block SHALL go directly to COMPLETE with error, type 3'd6, and the writer is never released.
REQ-020 LAUNCH: writer_resetn held 0 for exactly PARAM_RESTART_CYCLES cycles, router/address/length stable; then writer_resetn<=1 and go to RUN.
REQ-021 RUN: timeout counter increments each cycle.
  - writer_error -> COMPLETE/fail, capture i_wire_writer_error_type.
  - else writer_done -> COMPLETE/success.
  - else counter at 2^W-1 -> COMPLETE/fail, type 3'd7.
  - error takes precedence over simultaneous done.
REQ-022 COMPLETE (one cycle): pulse the granted channel's done or error bit; writer_resetn<=0; grant, router and busy cleared; rr_ptr<=granted index; go to IDLE.
REQ-023 Request deassertion after grant SHALL NOT abort the job; a request still high in IDLE after its pulse is a new job.
REQ-024 writer_resetn SHALL be 0 in every state except RUN.
REQ-025 At most one bit of done|error SHALL be set in any cycle, and never outside COMPLETE's output cycle.

Reset
REQ-026 While i_wire_resetn=0, the block SHALL be in state IDLE with all outputs 0 (grant, router, done, error, error_type, busy, writer_resetn, writer address/length), rr_ptr=3, and counters 0.
REQ-027 Reset asserted mid-job SHALL abort immediately, with no done/error pulse; after release, pending requests arbitrate from channel 0.

Verification
REQ-028 Case: request=4'b0001, addr0=0x1000, len0=16; writer_done 10 cycles after writer_resetn rises -> grant=0001, router=0001, writer_resetn low 2 cycles then high, done=0001 one cycle, busy drops.
REQ-029 Case: request=4'b1111 held -> grants in order 0001, 0010, 0100, 1000, 0001; each job separated by LAUNCH reset-low.
REQ-030 Case: len1=0, request=0010 -> error=0010 pulse, error_type=6, writer_resetn never high.
REQ-031 Case: writer_error with type 3'd2 and writer_done in the same cycle -> error pulse only, error_type=2.
REQ-032 Case: PARAM_TIMEOUT_WIDTH=4, writer silent -> error pulse 15 cycles into RUN, error_type=7.
REQ-033 Case: reset pulsed during RUN -> all outputs 0, no pulse, then a held request=0100 is re-granted.
